// File: rtl/math_game_pkg.sv
// Shared types and constants for the math game round controller.
// State encoding, datapath widths, LED bit positions and the display clamp.
package math_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGenA,
    StGenB,
    StShowA,
    StShowB,
    StWaitAns,
    StResult,
    StDone
  } state_e;

  localparam int unsigned OP_W     = 5;
  localparam int unsigned DISP_W   = 8;
  localparam int unsigned DISP_MAX = 99;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned LED_W    = 7;

  localparam int unsigned LED_CORRECT   = 6;
  localparam int unsigned LED_WRONG     = 5;
  localparam int unsigned LED_TIMED_OUT = 4;

  // The BCD converter downstream only handles two digits.
  function automatic logic [DISP_W-1:0] clamp_disp(input logic [DISP_W-1:0] v);
    return (v > DISP_W'(DISP_MAX)) ? DISP_W'(DISP_MAX) : v;
  endfunction

endpackage

// File: rtl/game_timer.sv
// Load/count/done down-counter shared by the timed phases of a round.
// done is high while the count is zero; load takes priority over counting.
module game_timer
  import math_game_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/math_game_round_ctrl.sv
// Round sequencer for the CPLD math game: operand capture, display, answer check, scoring.
// Optional feature macro MATH_GAME_SUB_EN: odd rounds become subtraction with ordered operands.
module math_game_round_ctrl
  import math_game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS     = 8,
  parameter int unsigned SHOW_CYCLES    = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned RESULT_CYCLES  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] answer,
  input  logic [4:0] rnd,
  output logic [7:0] disp_value,
  output logic [6:0] led,
  output logic [3:0] score,
  output logic       busy,
  output logic       game_over
);

  localparam int unsigned MAX_AB  = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > RESULT_CYCLES) ? MAX_AB : RESULT_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  state_e state_q, state_d;

  logic [OP_W-1:0]    op_a_q, op_b_q;
  logic [ROUND_W-1:0] score_q, round_q;
  logic               correct_q, wrong_q, timed_out_q;

  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_done;

  logic [DISP_W-1:0] sum_ab;
  logic [DISP_W-1:0] expected;
  logic              answer_ok;
  logic              round_last;

  logic [DISP_W-1:0] disp_d;
  logic [LED_W-1:0]  led_d;
  logic              busy_d, game_over_d;

  assign sum_ab = {3'b0, op_a_q} + {3'b0, op_b_q};

`ifdef MATH_GAME_SUB_EN
  logic              op_is_sub;
  logic [DISP_W-1:0] diff_ab;

  assign op_is_sub = round_q[0];
  // Operands are ordered in GEN_B, so the difference never wraps.
  assign diff_ab   = {3'b0, op_a_q} - {3'b0, op_b_q};
  assign expected  = op_is_sub ? diff_ab : sum_ab;
`else
  assign expected  = sum_ab;
`endif

  assign answer_ok  = (answer == expected);
  assign round_last = ((round_q + 4'd1) == ROUND_W'(NUM_ROUNDS));

  game_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_value),
    .count     (1'b1),
    .done      (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_q)
      StIdle:    if (start) state_d = StGenA;
      StGenA:    state_d = StGenB;
      StGenB:    state_d = StShowA;
      StShowA:   if (timer_done) state_d = StShowB;
      StShowB:   if (timer_done) state_d = StWaitAns;
      StWaitAns: if (submit || timer_done) state_d = StResult;
      StResult:  if (timer_done) state_d = round_last ? StDone : StGenA;
      StDone:    if (start) state_d = StGenA;
      default:   state_d = StIdle;
    endcase

    // Every timed phase reloads the shared timer on the edge that enters it.
    if (state_d != state_q) begin
      case (state_d)
        StShowA, StShowB: begin
          timer_load  = 1'b1;
          timer_value = TW'(SHOW_CYCLES - 1);
        end
        StWaitAns: begin
          timer_load  = 1'b1;
          timer_value = TW'(TIMEOUT_CYCLES - 1);
        end
        StResult: begin
          timer_load  = 1'b1;
          timer_value = TW'(RESULT_CYCLES - 1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      score_q     <= '0;
      round_q     <= '0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            score_q     <= '0;
            round_q     <= '0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            timed_out_q <= 1'b0;
          end
        end
        StGenA: op_a_q <= rnd;
        StGenB: begin
`ifdef MATH_GAME_SUB_EN
          if (op_is_sub && (rnd > op_a_q)) begin
            op_a_q <= rnd;
            op_b_q <= op_a_q;
          end else begin
            op_b_q <= rnd;
          end
`else
          op_b_q <= rnd;
`endif
        end
        StWaitAns: begin
          // A submit on the timeout cycle still counts as an answer.
          if (submit) begin
            correct_q <= answer_ok;
            wrong_q   <= !answer_ok;
            if (answer_ok) begin
              score_q <= score_q + 4'd1;
            end
          end else if (timer_done) begin
            timed_out_q <= 1'b1;
            wrong_q     <= 1'b1;
          end
        end
        StResult: begin
          if (timer_done) begin
            round_q <= round_q + 4'd1;
            if (!round_last) begin
              correct_q   <= 1'b0;
              wrong_q     <= 1'b0;
              timed_out_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_d      = '0;
    led_d       = {correct_q, wrong_q, timed_out_q, round_q};
    busy_d      = !((state_q == StIdle) || (state_q == StDone));
    game_over_d = (state_q == StDone);
    case (state_q)
      StShowA:   disp_d = {3'b0, op_a_q};
      StShowB:   disp_d = {3'b0, op_b_q};
      StWaitAns: disp_d = clamp_disp(answer);
      StResult:  disp_d = {4'b0, score_q};
      StDone:    disp_d = {4'b0, score_q};
      default:   disp_d = '0;
    endcase
`ifdef MATH_GAME_SUB_EN
    if ((state_q == StShowA) || (state_q == StShowB)) begin
      led_d[LED_CORRECT] = op_is_sub;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value <= '0;
      led        <= '0;
      score      <= '0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      disp_value <= disp_d;
      led        <= led_d;
      score      <= score_q;
      busy       <= busy_d;
      game_over  <= game_over_d;
    end
  end

endmodule

// File: tb/tb_math_game_round_ctrl.sv
// Self-checking bench for math_game_round_ctrl with a round-level reference model.
// Set MATH_GAME_SUB_EN to exercise the subtraction rounds as well.
module tb_math_game_round_ctrl;

  localparam int unsigned NR = 8;
  localparam int unsigned SC = 3;
  localparam int unsigned TC = 12;
  localparam int unsigned RC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [7:0] answer = '0;
  logic [4:0] rnd = '0;
  logic [7:0] disp_value;
  logic [6:0] led;
  logic [3:0] score;
  logic       busy;
  logic       game_over;

  int n_cmp = 0;
  int n_fail = 0;
  int m_round = 0;
  int m_score = 0;

  math_game_round_ctrl #(
    .NUM_ROUNDS    (NR),
    .SHOW_CYCLES   (SC),
    .TIMEOUT_CYCLES(TC),
    .RESULT_CYCLES (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .submit    (submit),
    .answer    (answer),
    .rnd       (rnd),
    .disp_value(disp_value),
    .led       (led),
    .score     (score),
    .busy      (busy),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start  = 1'($urandom);
    submit = 1'($urandom);
    rnd    = 5'($urandom);
  endtask

  function automatic int clamp99(int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic int model_exp(int a, int b);
`ifdef MATH_GAME_SUB_EN
    if ((m_round % 2) == 1) return (a > b) ? a - b : b - a;
`endif
    return a + b;
  endfunction

  task automatic start_game();
    start  = 1'b1;
    submit = 1'b0;
    tick();
    start   = 1'b0;
    m_round = 0;
    m_score = 0;
  endtask

  // Precondition: the DUT is in GEN_A for the next clock edge. d = submit delay in WAIT_ANS,
  // -1 for none. abort pulls rst on the second WAIT_ANS cycle.
  task automatic run_round(input int a, input int b, input int ans, input int d, input bit abort);
    int hi, lo, ex;
    bit sub_op, got_sub, c, to;
    sub_op = 1'b0;
`ifdef MATH_GAME_SUB_EN
    sub_op = ((m_round % 2) == 1);
`endif
    hi = a;
    lo = b;
    if (sub_op && (b > a)) begin
      hi = b;
      lo = a;
    end
    ex = model_exp(a, b);

    start  = 1'b0;
    submit = 1'b0;
    rnd    = 5'(a);
    tick();
    n_cmp++;
    if ({busy, game_over, led, score} !== {1'b1, 1'b0, 7'(m_round), 4'(m_score)}) begin
      n_fail++;
      $display("FAIL gen_a_status: {busy,game_over,led,score}=%h required %h",
               {busy, game_over, led, score}, {1'b1, 1'b0, 7'(m_round), 4'(m_score)});
    end
    rnd = 5'(b);
    tick();

    for (int i = 1; i <= int'(SC); i++) begin
      noise();
      tick();
      if (i == 1 || i == int'(SC)) begin
        n_cmp++;
        if ({led, disp_value} !== {sub_op, 2'b00, 4'(m_round), 8'(hi)}) begin
          n_fail++;
          $display("FAIL show_a[%0d]: led=%h disp=%0d required led=%h disp=%0d", i, led,
                   disp_value, {sub_op, 2'b00, 4'(m_round)}, hi);
        end
      end
    end
    for (int i = 1; i <= int'(SC); i++) begin
      noise();
      tick();
      if (i == 1 || i == int'(SC)) begin
        n_cmp++;
        if (disp_value !== 8'(lo)) begin
          n_fail++;
          $display("FAIL show_b[%0d]: disp=%0d required %0d", i, disp_value, lo);
        end
      end
    end

    answer  = 8'(ans);
    got_sub = 1'b0;
    for (int k = 1; k <= int'(TC); k++) begin
      start  = 1'($urandom);
      rnd    = 5'($urandom);
      submit = (k == d + 1);
      tick();
      submit = 1'b0;
      if (k == 1) begin
        n_cmp++;
        if ({disp_value, score} !== {8'(clamp99(ans)), 4'(m_score)}) begin
          n_fail++;
          $display("FAIL wait_entry: disp=%0d score=%0d required disp=%0d score=%0d",
                   disp_value, score, clamp99(ans), m_score);
        end
      end
      if (abort && k == 2) begin
        start = 1'b0;
        rst   = 1'b1;
        #1;
        n_cmp++;
        if ({disp_value, led, score, busy, game_over} !== 21'd0) begin
          n_fail++;
          $display("FAIL reset_mid_wait: outputs=%h required 0",
                   {disp_value, led, score, busy, game_over});
        end
        @(negedge clk);
        rst     = 1'b0;
        m_round = 0;
        m_score = 0;
        return;
      end
      if (k == d + 1) begin
        got_sub = 1'b1;
        break;
      end
      if (k == int'(TC)) begin
        n_cmp++;
        if (disp_value !== 8'(clamp99(ans))) begin
          n_fail++;
          $display("FAIL wait_last: disp=%0d required %0d", disp_value, clamp99(ans));
        end
      end
    end

    c  = got_sub && (ans == ex);
    to = !got_sub;
    m_score += int'(c);

    for (int i = 1; i <= int'(RC); i++) begin
      noise();
      tick();
      if (i == 1 || i == int'(RC)) begin
        n_cmp++;
        if ({disp_value, led, score} !== {8'(m_score), c, !c, to, 4'(m_round), 4'(m_score)}) begin
          n_fail++;
          $display("FAIL result[%0d]: disp=%0d led=%h score=%0d required disp=%0d led=%h score=%0d",
                   i, disp_value, led, score, m_score, {c, !c, to, 4'(m_round)}, m_score);
        end
      end
    end
    m_round++;
    start  = 1'b0;
    submit = 1'b0;

    if (m_round == int'(NR)) begin
      tick();
      n_cmp++;
      if ({busy, game_over, disp_value} !== {1'b0, 1'b1, 8'(m_score)}) begin
        n_fail++;
        $display("FAIL done: busy=%b game_over=%b disp=%0d required busy=0 game_over=1 disp=%0d",
                 busy, game_over, disp_value, m_score);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    submit = 1'b1;
    tick();
    submit = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({disp_value, led, score, busy, game_over} !== 21'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h required 0", tag, {disp_value, led, score, busy, game_over});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({disp_value, led, score, busy, game_over} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h required 0", {disp_value, led, score, busy, game_over});
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle("idle_submit_ignored");
  endtask

  task automatic test_correct();
    start_game();
    run_round(7, 12, model_exp(7, 12), 2, 1'b0);
  endtask

  task automatic test_wrong();
    run_round(7, 12, model_exp(7, 12) - 1, 5, 1'b0);
  endtask

  task automatic test_timeout();
    run_round(7, 12, model_exp(7, 12), -1, 1'b0);
  endtask

  task automatic test_submit_at_timeout();
    run_round(7, 12, model_exp(7, 12), int'(TC) - 1, 1'b0);
  endtask

  task automatic test_random_rounds();
    int a, b, ans, dd;
    while (m_round < int'(NR)) begin
      a   = int'($urandom_range(0, 31));
      b   = int'($urandom_range(0, 31));
      ans = ($urandom_range(0, 1) == 1) ? model_exp(a, b) : int'($urandom_range(0, 255));
      dd  = int'($urandom_range(0, TC));
      if (dd == int'(TC)) dd = -1;
      run_round(a, b, ans, dd, 1'b0);
    end
  endtask

  task automatic test_full_game();
    int a, b;
    start_game();
    for (int r = 0; r < int'(NR); r++) begin
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      run_round(a, b, model_exp(a, b), int'($urandom_range(0, TC - 1)), 1'b0);
    end
    n_cmp++;
    if (disp_value !== 8'd8) begin
      n_fail++;
      $display("FAIL full_game_score: disp=%0d required 8", disp_value);
    end
  endtask

  task automatic test_reset_mid_game();
    int a, b;
    start_game();
    for (int r = 0; r < 3; r++) begin
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      run_round(a, b, model_exp(a, b), int'($urandom_range(0, TC - 1)), 1'b0);
    end
    run_round(3, 4, 7, -1, 1'b1);
    check_idle("after_reset_idle");
  endtask

  task automatic test_after_reset();
    start_game();
    run_round(30, 31, model_exp(30, 31), 0, 1'b0);
`ifdef MATH_GAME_SUB_EN
    run_round(4, 20, 16, 1, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_timeout();
    test_submit_at_timeout();
    test_random_rounds();
    test_full_game();
    test_reset_mid_game();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
